// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT input-side stream controller.
//   state_e          : controller states (config, run, zero-pad)
//   FFT_DATA_W       : width of the FFT core data word {re, im}
//   SAMPLE_W         : width of one signed audio sample
//   CFG_W            : width of the FFT core config word
//   DEFAULT_CFG_WORD : config word sent after reset (bit0 = forward FFT)
package fft_ctrl_pkg;

  localparam int unsigned FFT_DATA_W = 32;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned CFG_W      = 16;

  localparam logic [CFG_W-1:0] DEFAULT_CFG_WORD = 16'h0001;

  typedef enum logic [1:0] {
    StCfg = 2'd0,
    StRun = 2'd1,
    StPad = 2'd2
  } state_e;

endpackage

// File: rtl/fft_stream_ctrl_if.sv
// AXI-Stream style links between the controller and the FFT core.
//   fft_tdata/fft_tvalid/fft_tlast/fft_tready : sample data channel
//   cfg_tdata/cfg_tvalid/cfg_tready           : config channel
// Modports: master = controller side, slave = FFT core side.
interface fft_stream_ctrl_if;
  import fft_ctrl_pkg::*;

  logic [FFT_DATA_W-1:0] fft_tdata;
  logic                  fft_tvalid;
  logic                  fft_tlast;
  logic                  fft_tready;
  logic [CFG_W-1:0]      cfg_tdata;
  logic                  cfg_tvalid;
  logic                  cfg_tready;

  modport master (
    output fft_tdata, fft_tvalid, fft_tlast, cfg_tdata, cfg_tvalid,
    input  fft_tready, cfg_tready
  );

  modport slave (
    input  fft_tdata, fft_tvalid, fft_tlast, cfg_tdata, cfg_tvalid,
    output fft_tready, cfg_tready
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO for audio samples; head is read straight from the storage
// registers, so a word pushed into an empty FIFO is visible the next cycle.
//   clk, rst (sync, active-high), flush : clock, reset, discard all entries
//   push, din                           : write port (caller must not push when full
//                                         unless popping in the same cycle)
//   pop                                 : advance head (caller must not pop when empty)
//   head, full, empty                   : read data and status
module sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Push+pop while full writes the slot being read; the old word is consumed this cycle.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fft_stream_ctrl.sv
// Input-side sequencer for the 512-point streaming FFT core.
// Sends the config word after reset (and on request at a frame boundary), buffers
// microphone samples and streams them as {sample, 16'b0} with tlast per frame.
// Ports:
//   clk_in, rst_in (sync, active-high)   : audio clock and reset
//   sample_in, sample_valid_in           : sample strobe from the deserialiser
//   cfg_req_in                           : request a config resend at the next boundary
//   bus (fft_stream_ctrl_if.master)      : data and config channels to the core
//   frame_count_out, overflow_out        : completed frames, sticky drop flag
//   cfg_done_out                         : at least one config handshake completed
//   frame_discard_out                    : only with FFT_STREAM_RESYNC_EN; pulses on the
//                                          tlast handshake of a zero-padded frame
// Build option FFT_STREAM_RESYNC_EN: a drop mid-frame flushes the FIFO and pads the
// rest of the frame with zeros so the core stays frame-aligned.
module fft_stream_ctrl import fft_ctrl_pkg::*; #(
  parameter int unsigned      FRAME_LEN  = 512,
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter logic [CFG_W-1:0] CFG_WORD   = DEFAULT_CFG_WORD
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic                cfg_req_in,
  fft_stream_ctrl_if.master   bus,
  output logic [15:0]         frame_count_out,
  output logic                overflow_out,
  output logic                cfg_done_out
`ifdef FFT_STREAM_RESYNC_EN
  ,
  output logic                frame_discard_out
`endif
);

  localparam int unsigned IdxW = $clog2(FRAME_LEN);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d, idx_next;
  logic                 pending_q, cfg_valid_q, stall_q, overflow_q, cfg_done_q;
  logic [15:0]          frame_cnt_q;

  logic                 idx_last, idx_zero, frame_end;
  logic                 data_valid, data_hs, cfg_hs, go_cfg, drop;
  logic [FFT_DATA_W-1:0] data;
  logic                 fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]  fifo_head;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (sample_in),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign idx_last = (idx_q == IdxW'(FRAME_LEN - 1));
  assign idx_zero = (idx_q == '0);
  assign idx_next = idx_last ? '0 : idx_q + 1'b1;

  // Data channel. With a config pending at a boundary, tvalid is held off so the
  // FSM can leave for CFG; a word already stalled on the bus is kept until accepted.
  always_comb begin
    data_valid = 1'b0;
    data       = '0;
    unique case (state_q)
      StRun: begin
        data_valid = !fifo_empty && (!(pending_q && idx_zero) || stall_q);
        if (data_valid) data = {fifo_head, {(FFT_DATA_W - SAMPLE_W){1'b0}}};
      end
      StPad:   data_valid = 1'b1;
      default: ;
    endcase
  end

  assign data_hs   = data_valid && bus.fft_tready;
  assign cfg_hs    = cfg_valid_q && bus.cfg_tready;
  assign frame_end = data_hs && idx_last;

  assign fifo_pop  = data_hs && (state_q == StRun);
  // Samples arriving during PAD are discarded on purpose and are not drops.
  assign drop      = sample_valid_in && fifo_full && !fifo_pop && (state_q != StPad);
  assign fifo_push = sample_valid_in && !drop && (state_q != StPad);

`ifdef FFT_STREAM_RESYNC_EN
  assign fifo_flush        = drop && (state_q == StRun) && !idx_zero;
  assign frame_discard_out = frame_end && (state_q == StPad);
`else
  assign fifo_flush = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    go_cfg  = 1'b0;
    unique case (state_q)
      StCfg: if (cfg_hs) state_d = StRun;
      StRun: begin
        if (data_hs) begin
          idx_d = idx_next;
        end else if (pending_q && idx_zero && !data_valid) begin
          state_d = StCfg;
          go_cfg  = 1'b1;
        end
        // A drop implies no handshake and a non-zero index, so nothing above fires.
        if (fifo_flush) state_d = StPad;
      end
      StPad: begin
        if (data_hs) begin
          idx_d = idx_next;
          if (idx_last) state_d = StRun;
        end
      end
      default: state_d = StCfg;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StCfg;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      overflow_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      // A request in the same cycle as entering CFG is kept for the next boundary.
      pending_q   <= cfg_req_in | (pending_q & ~go_cfg);
      cfg_valid_q <= (state_d == StCfg);
      stall_q     <= data_valid & ~bus.fft_tready;
      overflow_q  <= overflow_q | drop;
      cfg_done_q  <= cfg_done_q | cfg_hs;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.fft_tdata  = data;
  assign bus.fft_tvalid = data_valid;
  assign bus.fft_tlast  = data_valid && idx_last;
  assign bus.cfg_tvalid = cfg_valid_q;
  assign bus.cfg_tdata  = cfg_valid_q ? CFG_WORD : '0;

  assign frame_count_out = frame_cnt_q;
  assign overflow_out    = overflow_q;
  assign cfg_done_out    = cfg_done_q;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl: directed phases with random data/backpressure, checked
// against a queue model of accepted samples, frame position and frame count.
module tb_fft_stream_ctrl;

  localparam int FrameLen  = 512;
  localparam int FifoDepth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        cfg_req = 1'b0;
  logic [15:0] frame_count;
  logic        overflow;
  logic        cfg_done;
`ifdef FFT_STREAM_RESYNC_EN
  logic        frame_discard;
`endif

  fft_stream_ctrl_if bus_if ();

  fft_stream_ctrl dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sample_in       (sample),
    .sample_valid_in (sample_valid),
    .cfg_req_in      (cfg_req),
    .bus             (bus_if),
    .frame_count_out (frame_count),
    .overflow_out    (overflow),
    .cfg_done_out    (cfg_done)
`ifdef FFT_STREAM_RESYNC_EN
    ,
    .frame_discard_out (frame_discard)
`endif
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  logic [15:0] q[$];
  int          model_idx = 0;
  int          exp_frames = 0;
  bit          exp_ovf = 1'b0;
  bit          pad_mode = 1'b0;
  bit          skip_stab = 1'b0;
  int          data_hs_cnt = 0;
  int          cfg_hs_cnt = 0;
  int          cfg_hs_idx = -1;
  int          cfg_hs_frames = -1;
  int          discard_cnt = 0;
  bit          prev_stall = 1'b0;
  bit          prev_cfg_stall = 1'b0;
  logic [31:0] prev_tdata = '0;
  logic        prev_tlast = 1'b0;
  logic [15:0] seq = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set at the preceding negedge; observe, update model, advance.
  task automatic cycle();
    bit          hs, in_pad;
    logic [31:0] exp_d;
    #1;
    in_pad = pad_mode;
    if (bus_if.cfg_tvalid === 1'b1) begin
      chk("cfg_tdata", 32'(bus_if.cfg_tdata), 32'h0001);
      chk("fft_tvalid_during_cfg", 32'(bus_if.fft_tvalid), 0);
    end
    if (prev_cfg_stall) chk("cfg_tvalid_hold", 32'(bus_if.cfg_tvalid), 1);
    if (bus_if.cfg_tvalid && bus_if.cfg_tready) begin
      cfg_hs_cnt++;
      cfg_hs_idx    = model_idx;
      cfg_hs_frames = exp_frames;
    end
    prev_cfg_stall = bus_if.cfg_tvalid && !bus_if.cfg_tready;

    if (prev_stall && !skip_stab) begin
      chk("tvalid_hold", 32'(bus_if.fft_tvalid), 1);
      chk("tdata_hold", bus_if.fft_tdata, prev_tdata);
      chk("tlast_hold", 32'(bus_if.fft_tlast), 32'(prev_tlast));
    end
    skip_stab = 1'b0;

    hs = bus_if.fft_tvalid && bus_if.fft_tready;
    if (hs) begin
      data_hs_cnt++;
      if (in_pad)              exp_d = '0;
      else if (q.size() != 0)  exp_d = {q.pop_front(), 16'h0000};
      else                     exp_d = 32'hDEAD_BEEF;  // no sample should be on the bus
      chk("tdata", bus_if.fft_tdata, exp_d);
      chk("tlast", 32'(bus_if.fft_tlast), 32'(model_idx == FrameLen - 1));
`ifdef FFT_STREAM_RESYNC_EN
      chk("frame_discard", 32'(frame_discard), 32'(in_pad && model_idx == FrameLen - 1));
`endif
      if (model_idx == FrameLen - 1) begin
        model_idx = 0;
        exp_frames++;
        pad_mode = 1'b0;
      end else begin
        model_idx++;
      end
    end
`ifdef FFT_STREAM_RESYNC_EN
    if (frame_discard === 1'b1) discard_cnt++;
`endif

    if (sample_valid && !in_pad) begin
      if (q.size() < FifoDepth) begin
        q.push_back(sample);
      end else begin
        exp_ovf = 1'b1;
`ifdef FFT_STREAM_RESYNC_EN
        if (model_idx != 0) begin
          pad_mode  = 1'b1;
          skip_stab = 1'b1;
          q.delete();
        end
`endif
      end
    end

    prev_stall = bus_if.fft_tvalid && !bus_if.fft_tready;
    prev_tdata = bus_if.fft_tdata;
    prev_tlast = bus_if.fft_tlast;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    sample_valid       = 1'b0;
    cfg_req            = 1'b0;
    bus_if.fft_tready  = 1'b1;
    while ((q.size() != 0 || pad_mode) && n < 1000) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_in_time"}, 32'(n < 1000), 1);
    cycle();
    cycle();
    chk({tag, "_idle_tvalid"}, 32'(bus_if.fft_tvalid), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames[15:0]));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    int n;
    int hs_base;
    int frames_req;
    bit req_sent;

    bus_if.fft_tready = 1'b0;
    bus_if.cfg_tready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg_tvalid", 32'(bus_if.cfg_tvalid), 0);
    chk("rst_fft_tvalid", 32'(bus_if.fft_tvalid), 0);
    chk("rst_tdata", bus_if.fft_tdata, 0);
    chk("rst_tlast", 32'(bus_if.fft_tlast), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Initial config with 5 stalled cycles
    n = 0;
    while (bus_if.cfg_tvalid !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    chk("cfg_tvalid_rises", 32'(n < 10), 1);
    for (int i = 0; i < 5; i++) begin
      chk("cfg_tvalid_stalled", 32'(bus_if.cfg_tvalid), 1);
      chk("no_data_before_cfg", 32'(bus_if.fft_tvalid), 0);
      chk("cfg_done_before_hs", 32'(cfg_done), 0);
      cycle();
    end
    bus_if.cfg_tready = 1'b1;
    cycle();
    chk("cfg_done_after_hs", 32'(cfg_done), 1);
    chk("cfg_tvalid_drops", 32'(bus_if.cfg_tvalid), 0);
    repeat (4) cycle();
    chk("cfg_hs_once", 32'(cfg_hs_cnt), 1);

    // 1024 back-to-back samples, value = index
    hs_base = data_hs_cnt;
    bus_if.fft_tready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      sample       = 16'(i);
      sample_valid = 1'b1;
      cycle();
    end
    drain("burst");
    chk("burst_handshakes", 32'(data_hs_cnt - hs_base), 1024);
    chk("burst_frames", 32'(frame_count), 2);
    chk("burst_no_overflow", 32'(overflow), 0);

    // Sparse samples with random backpressure
    for (int k = 0; k < 800; k++) begin
      sample_valid      = (k % 4 == 0);
      sample            = 16'($urandom);
      bus_if.fft_tready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain("sparse");
    chk("sparse_no_overflow", 32'(overflow), 0);

    // Nine samples into a stalled 8-deep FIFO
    hs_base = data_hs_cnt;
    bus_if.fft_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample       = 16'h8000 | 16'(i);
      sample_valid = 1'b1;
      cycle();
    end
    sample_valid = 1'b0;
    cycle();
    chk("ovf_set", 32'(overflow), 1);
    repeat (3) cycle();
    chk("ovf_sticky_stalled", 32'(overflow), 1);
    drain("ovf");
`ifndef FFT_STREAM_RESYNC_EN
    chk("ovf_emitted_8", 32'(data_hs_cnt - hs_base), 8);
`endif

    // Reconfig request at frame index 100
    req_sent   = 1'b0;
    frames_req = 0;
    n          = 0;
    sample_valid      = 1'b1;
    bus_if.fft_tready = 1'b1;
    while (n < 2500 && !(req_sent && exp_frames > frames_req && model_idx >= 20)) begin
      cfg_req = (!req_sent && model_idx == 100);
      if (cfg_req) begin
        req_sent   = 1'b1;
        frames_req = exp_frames;
      end
      sample = seq;
      seq++;
      cycle();
      n++;
    end
    cfg_req = 1'b0;
    chk("reconfig_in_time", 32'(n < 2500), 1);
    drain("reconfig");
    chk("reconfig_hs_count", 32'(cfg_hs_cnt), 2);
    chk("reconfig_at_boundary", 32'(cfg_hs_idx), 0);
    chk("reconfig_after_tlast", 32'(cfg_hs_frames), 32'(frames_req + 1));

`ifdef FFT_STREAM_RESYNC_EN
    // Drop at index 300 -> zero padding to the end of the frame
    discard_cnt  = 0;
    n            = 0;
    sample_valid = 1'b1;
    while (model_idx != 300 && n < 2000) begin
      sample = seq;
      seq++;
      cycle();
      n++;
    end
    chk("resync_reach_300", 32'(model_idx), 300);
    bus_if.fft_tready = 1'b0;
    n = 0;
    while (!pad_mode && n < 20) begin
      sample = seq;
      seq++;
      cycle();
      n++;
    end
    chk("resync_drop_seen", 32'(n < 20), 1);
    bus_if.fft_tready = 1'b1;
    n = 0;
    while (pad_mode && n < 600) begin
      sample = seq;
      seq++;
      cycle();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      sample = seq;
      seq++;
      cycle();
    end
    drain("resync");
    chk("resync_discard_once", 32'(discard_cnt), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
